// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-position counter width; never narrower than one bit so WIDTH=1 still builds.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and serial_adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  ready, busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output ready, busy, done, sum, c_out
  );

endinterface

// File: rtl/F_A.sv
// One-bit full-adder cell; purely combinational.
module F_A (
  input  logic A,
  input  logic B,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = A ^ B ^ c_in;
  assign c_out = (A & B) | (c_in & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: drives one full-adder cell per clock, LSB first,
// carrying between cycles in a register. Result and carry-out are held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_sr_q;
  logic [WIDTH-1:0]  b_sr_q;
  logic [WIDTH-1:0]  sum_sr_q;
  logic [WIDTH-1:0]  sum_sr_d;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  sum_q;
  logic              c_out_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              fa_s;
  logic              fa_c;

  F_A u_fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .c_in (carry_q),
    .sum  (fa_s),
    .c_out(fa_c)
  );

  // The new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_sum_one
    assign sum_sr_d = fa_s;
  end else begin : g_sum_wide
    assign sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_sr_q   <= bus.a;
            b_sr_q   <= bus.b;
            sum_sr_q <= '0;
            carry_q  <= bus.c_in;
            cnt_q    <= '0;
            state_q  <= StRun;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StDone;
            sum_q   <= sum_sr_d;
            c_out_q <= fa_c;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against plain-arithmetic expectations.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation; scramble inputs after acceptance.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       output int lat, output logic [7:0] s, output logic co,
                       output logic rdy, output int pulses);
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.c_in  = cv;
    tick();
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.c_in  = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus8.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    s      = bus8.sum;
    co     = bus8.c_out;
    rdy    = bus8.ready;
    pulses = (lat > 0) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus8.done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;
    repeat (3) tick();
    total++; if (bus8.ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready: got %b want 1", bus8.ready); end
    total++; if (bus8.busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++;
      $display("FAIL reset_done: got %b want 0", bus8.done); end
    total++; if (bus8.sum !== 8'h00 || bus8.c_out !== 1'b0) begin bad++;
      $display("FAIL reset_result: got %h/%b want 00/0", bus8.sum, bus8.c_out); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_directed();
    logic [7:0] va [3] = '{8'h3C, 8'hFF, 8'hA5};
    logic [7:0] vb [3] = '{8'h42, 8'h01, 8'h5A};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h7E, 8'h00, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    int lat, pulses;
    logic [7:0] s;
    logic co, rdy;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], lat, s, co, rdy, pulses);
      total++; if (lat != 8) begin bad++;
        $display("FAIL directed_latency[%0d]: got %0d want 8", i, lat); end
      total++; if (s !== es[i] || co !== ec[i]) begin bad++;
        $display("FAIL directed_result[%0d]: got %h/%b want %h/%b", i, s, co, es[i], ec[i]); end
      total++; if (rdy !== 1'b1 || pulses != 1) begin bad++;
        $display("FAIL directed_done[%0d]: got ready=%b pulses=%0d want 1/1", i, rdy, pulses); end
    end
  endtask

  task automatic test_random();
    int lat, pulses, errs;
    logic [7:0] s, x, y;
    logic co, rdy, c;
    logic [8:0] exp;
    errs = 0;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      exp = ref_add(x, y, c);
      do_op(x, y, c, lat, s, co, rdy, pulses);
      total++;
      if ({co, s} !== exp || lat != 8 || pulses != 1) begin bad++; errs++;
        $display("FAIL random[%0d] %h+%h+%b: got %b%h lat=%0d pulses=%0d want %h lat=8 pulses=1",
                 i, x, y, c, co, s, lat, pulses, exp);
      end
    end
  endtask

  task automatic test_ignored_start();
    int pulses, lat;
    logic bsy, rdy;
    bus8.start = 1'b1; bus8.a = 8'h3C; bus8.b = 8'h42; bus8.c_in = 1'b0;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    bsy = bus8.busy; rdy = bus8.ready;
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h11; bus8.c_in = 1'b1;
    tick();
    bus8.start = 1'b0;
    total++; if (bsy !== 1'b1 || rdy !== 1'b0) begin bad++;
      $display("FAIL ignore_flags: got busy=%b ready=%b want 1/0", bsy, rdy); end
    pulses = 0; lat = -1;
    for (int k = 5; k <= 30; k++) begin
      tick();
      if (bus8.done === 1'b1) begin pulses++; if (lat < 0) lat = k; end
    end
    total++; if (pulses != 1 || lat != 8) begin bad++;
      $display("FAIL ignore_pulses: got %0d at %0d want 1 at 8", pulses, lat); end
    total++; if (bus8.sum !== 8'h7E || bus8.c_out !== 1'b0) begin bad++;
      $display("FAIL ignore_result: got %h/%b want 7e/0", bus8.sum, bus8.c_out); end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic held;
    logic [7:0] s1;
    logic co1;
    c1 = -1; c2 = -1; held = 1'b1;
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.c_in = 1'b0;
    tick();
    bus8.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus8.done === 1'b1) begin c1 = cyc; break; end
    end
    s1 = bus8.sum; co1 = bus8.c_out;
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.c_in = 1'b0;
    tick();
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    for (int k = 0; k < 20; k++) begin
      if (bus8.done === 1'b1) begin c2 = cyc; break; end
      if (bus8.sum !== 8'h02 || bus8.c_out !== 1'b0) held = 1'b0;
      tick();
    end
    total++; if (s1 !== 8'h02 || co1 !== 1'b0) begin bad++;
      $display("FAIL b2b_first: got %h/%b want 02/0", s1, co1); end
    total++; if (held !== 1'b1) begin bad++;
      $display("FAIL b2b_hold: got %b want 1", held); end
    total++; if (c1 < 0 || c2 < 0 || c2 - c1 != 9) begin bad++;
      $display("FAIL b2b_spacing: got %0d want 9", c2 - c1); end
    total++; if (bus8.sum !== 8'h00 || bus8.c_out !== 1'b1) begin bad++;
      $display("FAIL b2b_second: got %h/%b want 00/1", bus8.sum, bus8.c_out); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    logic bsy;
    int lat, p;
    logic [7:0] s;
    logic co, rdy;
    // Leave a non-zero result in place first so the clear is observable.
    do_op(8'h3C, 8'h42, 1'b1, lat, s, co, rdy, p);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c_in = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    bsy = bus8.busy;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bsy !== 1'b1) begin bad++;
      $display("FAIL midrst_busy_before: got %b want 1", bsy); end
    total++; if (bus8.sum !== 8'h00 || bus8.c_out !== 1'b0 || bus8.busy !== 1'b0 ||
                 bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin bad++;
      $display("FAIL midrst_clear: got sum=%h c=%b busy=%b ready=%b done=%b want 00/0/0/1/0",
               bus8.sum, bus8.c_out, bus8.busy, bus8.ready, bus8.done); end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus8.done === 1'b1) pulses++;
    end
    total++; if (pulses != 0 || bus8.ready !== 1'b1) begin bad++;
      $display("FAIL midrst_after: got pulses=%0d ready=%b want 0/1", pulses, bus8.ready); end
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    logic x, y, c, d;
    for (int i = 0; i < 8; i++) begin
      x = i[2]; y = i[1]; c = i[0];
      exp = {1'b0, x} + {1'b0, y} + {1'b0, c};
      bus1.start = 1'b1; bus1.a = x; bus1.b = y; bus1.c_in = c;
      tick();
      bus1.start = 1'b0; bus1.a = ~x; bus1.b = ~y; bus1.c_in = ~c;
      tick();
      d = bus1.done;
      total++;
      if (d !== 1'b1 || {bus1.c_out, bus1.sum} !== exp) begin bad++;
        $display("FAIL w1[%0d]: got done=%b %b%b want done=1 %b",
                 i, d, bus1.c_out, bus1.sum, exp);
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
